// File: rtl/hdmi_config_sequencer.sv
// hdmi_config_sequencer
// Walks the fixed ADV7513 register initialisation list and hands it to the
// I2C write engine one 24-bit write at a time. After a power-up delay it
// issues each entry, waits for the engine to accept and finish it, then
// leaves a bus-free gap. An attempt that times out is retried a bounded
// number of times before the sequencer parks in ERROR. A start pulse or a
// hot-plug rising edge re-runs the whole list. A transfer that is already
// in flight is always allowed to finish first.
//
// Ports
//   refClock     in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle request to re-run the configuration
//   hotPlug      in   asynchronous HPD pin, synchronised internally
//   i2cComplete  in   engine status: 1 = idle/finished, 0 = busy
//   i2cGo        out  registered request to the engine
//   i2cData      out  {SLAVE_ADDR, regAddr, regValue} of the current entry
//   configIndex  out  current table entry, 0..9
//   configDone   out  every entry has been written
//   configError  out  an entry failed after all of its retries
//
// state        | meaning
// -------------+------------------------------------------------------
// POWERUP      | count the power-up delay; a restart clears the count
// ISSUE        | clear the timeout counter, raise go on the next edge
// WAIT_ACCEPT  | go held high until the engine reports busy
// WAIT_DONE    | go low, wait for the engine to report finished
// GAP          | bus-free time, then next entry / retry / restart / done
// DONE         | whole list written; hold
// ERROR        | an entry exhausted its retries; hold

module hdmi_config_sequencer #(
    parameter logic [7:0] SLAVE_ADDR     = 8'h72,
    parameter int         POWERUP_CYCLES = 50000,
    parameter int         GAP_CYCLES     = 8,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic        refClock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        hotPlug,
    input  logic        i2cComplete,
    output logic        i2cGo,
    output logic [23:0] i2cData,
    output logic [3:0]  configIndex,
    output logic        configDone,
    output logic        configError
);

    localparam logic [15:0] PWR_LAST   = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [12:0] TMO_LAST   = 13'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRIES);
    localparam logic [3:0]  LAST_INDEX = 4'd9;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_ISSUE,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [12:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [3:0]  index_q, index_d;
    logic        pending_q, pending_d;
    logic        retry_gap_q, retry_gap_d;
    logic        go_q, go_d;
    logic [2:0]  hp_sync_q, hp_sync_d;
    logic        restart;
    logic        busy;
    logic        abort;
    logic [15:0] reg_word;

    // hp_sync_q[1:0] is the two-flop synchroniser, hp_sync_q[2] the edge register.
    assign restart = start | (hp_sync_q[1] & ~hp_sync_q[2]);
    assign busy    = (state_q == S_ISSUE) || (state_q == S_WAIT_ACCEPT) ||
                     (state_q == S_WAIT_DONE) || (state_q == S_GAP);

    always_comb begin
        case (index_q)
            4'd0:    reg_word = 16'h4110;
            4'd1:    reg_word = 16'h9803;
            4'd2:    reg_word = 16'h9AE0;
            4'd3:    reg_word = 16'h9C30;
            4'd4:    reg_word = 16'h9D61;
            4'd5:    reg_word = 16'hA2A4;
            4'd6:    reg_word = 16'hA3A4;
            4'd7:    reg_word = 16'hE0D0;
            4'd8:    reg_word = 16'hF900;
            4'd9:    reg_word = 16'h1500;
            default: reg_word = 16'h4110;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_d     = retry_q;
        index_d     = index_q;
        pending_d   = pending_q;
        retry_gap_d = retry_gap_q;
        abort       = 1'b0;
        hp_sync_d   = {hp_sync_q[1:0], hotPlug};

        // Restarts during a transfer are deferred to the end of the gap.
        if (restart && busy) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_POWERUP: begin
                if (restart) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == PWR_LAST) begin
                    state_d    = S_ISSUE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                if (!i2cComplete) begin
                    state_d = S_WAIT_DONE;
                    if (tmo_cnt_q != TMO_LAST) begin
                        tmo_cnt_d = tmo_cnt_q + 13'd1;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 13'd1;
                end
            end
            S_WAIT_DONE: begin
                // A completion on the last allowed cycle still counts.
                if (i2cComplete) begin
                    state_d     = S_GAP;
                    wait_cnt_d  = '0;
                    retry_gap_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 13'd1;
                end
            end
            S_GAP: begin
                if (wait_cnt_q == GAP_LAST) begin
                    wait_cnt_d = '0;
                    if (pending_q || restart) begin
                        state_d     = S_POWERUP;
                        pending_d   = 1'b0;
                        index_d     = '0;
                        retry_d     = '0;
                        retry_gap_d = 1'b0;
                    end else if (retry_gap_q) begin
                        state_d = S_ISSUE;
                    end else if (index_q == LAST_INDEX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        retry_d = '0;
                        state_d = S_ISSUE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d     = S_POWERUP;
                    wait_cnt_d  = '0;
                    index_d     = '0;
                    retry_d     = '0;
                    retry_gap_d = 1'b0;
                end
            end
            default: state_d = S_POWERUP;
        endcase

        // Timed-out attempt: re-issue the same entry after a gap, or give up.
        if (abort) begin
            if (retry_q < RETRY_MAX) begin
                retry_d     = retry_q + 2'd1;
                retry_gap_d = 1'b1;
                state_d     = S_GAP;
                wait_cnt_d  = '0;
            end else begin
                state_d = S_ERROR;
            end
        end

        go_d = (state_d == S_WAIT_ACCEPT);
    end

    always_ff @(posedge refClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_POWERUP;
            wait_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            index_q     <= '0;
            pending_q   <= 1'b0;
            retry_gap_q <= 1'b0;
            go_q        <= 1'b0;
            hp_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            index_q     <= index_d;
            pending_q   <= pending_d;
            retry_gap_q <= retry_gap_d;
            go_q        <= go_d;
            hp_sync_q   <= hp_sync_d;
        end
    end

    assign i2cGo       = go_q;
    assign i2cData     = {SLAVE_ADDR, reg_word};
    assign configIndex = index_q;
    assign configDone  = (state_q == S_DONE);
    assign configError = (state_q == S_ERROR);

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
module tb_hdmi_config_sequencer;

    localparam int P = 20;
    localparam int G = 8;
    localparam int T = 64;
    localparam int R = 3;

    logic        refClock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        hotPlug;
    logic        i2cComplete;
    logic        i2cGo;
    logic [23:0] i2cData;
    logic [3:0]  configIndex;
    logic        configDone;
    logic        configError;

    hdmi_config_sequencer #(
        .SLAVE_ADDR(8'h72), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .MAX_RETRIES(R)
    ) dut (
        .refClock(refClock), .reset_n(reset_n), .start(start), .hotPlug(hotPlug),
        .i2cComplete(i2cComplete), .i2cGo(i2cGo), .i2cData(i2cData),
        .configIndex(configIndex), .configDone(configDone), .configError(configError)
    );

    always #5 refClock = ~refClock;

    typedef struct { int cyc; int idx; logic [23:0] data; } att_t;
    typedef struct { int rel; int idx; } exp_t;
    typedef struct { int ent; int nign; int attempts; logic done; logic err; int idx; } vec_t;

    logic [23:0] tbl [10] = '{24'h724110, 24'h729803, 24'h729AE0, 24'h729C30, 24'h729D61,
                              24'h72A2A4, 24'h72A3A4, 24'h72E0D0, 24'h72F900, 24'h721500};

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    int   ab = 0;
    att_t att_q[$];
    exp_t exp_q[$];
    int   exp_done, exp_err, exp_last;
    int   done_abs = -1;
    int   err_abs = -1;
    logic go_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;
    int   ign_cfg [10];
    vec_t vecs [7];

    always @(posedge refClock) cyc <= cyc + 1;

    // Monitor: every rising i2cGo is one attempt; record flag rises.
    always @(negedge refClock) begin
        go_prev   <= i2cGo;
        done_prev <= configDone;
        err_prev  <= configError;
        if (i2cGo && !go_prev) att_q.push_back('{cyc, int'(configIndex), i2cData});
        if (configDone && !done_prev) done_abs <= cyc;
        if (configError && !err_prev) err_abs <= cyc;
    end

    // Engine model: low 2 cycles after go, high 30 cycles later; ignores
    // entry i the first ign_cfg[i] times it is requested after a reset.
    initial begin : engine
        int phase;
        int cnt;
        int ign_done [10];
        phase = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) ign_done[i] = 0;
        i2cComplete = 1'b1;
        forever begin
            @(negedge refClock);
            if (!reset_n) begin
                i2cComplete = 1'b1;
                phase = 0;
                for (int i = 0; i < 10; i++) ign_done[i] = 0;
            end else begin
                case (phase)
                    0: if (i2cGo) begin
                        if (ign_done[configIndex] < ign_cfg[configIndex]) begin
                            ign_done[configIndex]++;
                            phase = 3;
                        end else begin
                            phase = 1;
                            cnt = 1;
                        end
                    end
                    1: begin
                        cnt++;
                        if (cnt == 2) begin
                            i2cComplete = 1'b0;
                            phase = 2;
                            cnt = 0;
                        end
                    end
                    2: begin
                        cnt++;
                        if (cnt == 30) begin
                            i2cComplete = 1'b1;
                            phase = 0;
                        end
                    end
                    default: if (!i2cGo) phase = 0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference timeline from the protocol rules: first go P+1 cycles after
    // release; a served write frees the bus 32 cycles after go, a timed-out
    // one T cycles after go; the next go follows G+1 cycles later.
    task automatic model(input int ign [10]);
        int c;
        exp_q.delete();
        exp_done = -1;
        exp_err = -1;
        exp_last = 9;
        c = P + 1;
        for (int i = 0; i < 10; i++) begin
            for (int a = 0; a <= R; a++) begin
                exp_q.push_back('{c, i});
                if (a < ign[i]) begin
                    if (a == R) begin
                        exp_err = c + T;
                        exp_last = i;
                        return;
                    end
                    c += T + G + 1;
                end else begin
                    if (i == 9) exp_done = c + 32 + G;
                    c += 32 + G + 1;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge refClock);
        ab = att_q.size();
        reset_n = 1'b1;
        base = cyc;
    endtask

    task automatic run_to_end(input string name);
        int n;
        n = 0;
        while (!(configDone || configError) && n < 20000) begin
            @(negedge refClock);
            n++;
        end
        check({name, "_finished"}, 32'(configDone || configError), 32'd1);
        repeat (60) @(negedge refClock);
    endtask

    task automatic wait_attempts(input string name, input int want);
        int n;
        n = 0;
        while (att_q.size() < want && n < 5000) begin
            @(negedge refClock);
            n++;
        end
        check({name, "_arrived"}, 32'(att_q.size() >= want), 32'd1);
    endtask

    task automatic compare_model(input string name);
        int n;
        n = att_q.size() - ab;
        check({name, "_count"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            check({name, "_idx"}, att_q[ab+k].idx, exp_q[k].idx);
            check({name, "_cyc"}, att_q[ab+k].cyc - base, exp_q[k].rel);
            check({name, "_data"}, att_q[ab+k].data, tbl[exp_q[k].idx]);
        end
        check({name, "_done_cyc"}, (done_abs > base) ? done_abs - base : -1, exp_done);
        check({name, "_err_cyc"}, (err_abs > base) ? err_abs - base : -1, exp_err);
        check({name, "_index"}, configIndex, exp_last);
        check({name, "_done"}, configDone, exp_done >= 0);
        check({name, "_error"}, configError, exp_err >= 0);
        check({name, "_go"}, i2cGo, 1'b0);
    endtask

    initial begin
        int ign [10];
        int n;
        vecs[0] = '{0, 0, 10, 1'b1, 1'b0, 0};
        vecs[1] = '{3, 2, 12, 1'b1, 1'b0, 9};
        vecs[2] = '{9, 3, 13, 1'b1, 1'b0, 9};
        vecs[3] = '{7, 1, 11, 1'b1, 1'b0, 9};
        vecs[4] = '{0, 4, 4, 1'b0, 1'b1, 0};
        vecs[5] = '{9, 4, 13, 1'b0, 1'b1, 9};
        vecs[6] = '{5, 4, 9, 1'b0, 1'b1, 5};
        vecs[0].idx = 9;

        for (int i = 0; i < 10; i++) ign_cfg[i] = 0;
        reset_n = 1'b0;
        start = 1'b0;
        hotPlug = 1'b0;
        repeat (3) @(negedge refClock);
        check("rst_go", i2cGo, 1'b0);
        check("rst_index", configIndex, 4'd0);
        check("rst_done", configDone, 1'b0);
        check("rst_error", configError, 1'b0);
        check("rst_data", i2cData, 24'h724110);

        // Table-driven scenarios: one entry stalled a given number of times.
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 10; i++) ign[i] = 0;
            ign[vecs[r].ent] = vecs[r].nign;
            ign_cfg = ign;
            do_reset();
            model(ign);
            run_to_end("vec");
            compare_model("vec_model");
            check("vec_attempts", att_q.size() - ab, vecs[r].attempts);
            check("vec_done", configDone, vecs[r].done);
            check("vec_error", configError, vecs[r].err);
            check("vec_index", configIndex, vecs[r].idx);
            if (vecs[r].nign == 0) begin
                check("nominal_first", att_q[ab].data, 24'h724110);
                check("nominal_last", att_q[ab+9].data, 24'h721500);
            end
        end

        // Still in ERROR from the last row: a start pulse restarts from index 0.
        check("err_go_low", i2cGo, 1'b0);
        @(negedge refClock) start = 1'b1;
        @(negedge refClock) start = 1'b0;
        check("start_clears_error", configError, 1'b0);
        check("start_index0", configIndex, 4'd0);
        base = cyc;
        ab = att_q.size();
        wait_attempts("start_first", ab + 1);
        check("start_first_cyc", att_q[ab].cyc - base, P + 1);
        check("start_first_idx", att_q[ab].idx, 0);
        run_to_end("start");
        check("start_attempts", att_q.size() - ab, 10);
        check("start_done", configDone, 1'b1);

        // Hot-plug (plus a start) while entry 2 is in WAIT_DONE.
        for (int i = 0; i < 10; i++) ign_cfg[i] = 0;
        do_reset();
        n = 0;
        while (!(configIndex == 4'd2 && !i2cComplete && !i2cGo) && n < 5000) begin
            @(negedge refClock);
            n++;
        end
        check("hp_reached_entry2", 32'(n < 5000), 32'd1);
        hotPlug = 1'b1;
        @(negedge refClock) start = 1'b1;
        @(negedge refClock) start = 1'b0;
        wait_attempts("hp_next", ab + 4);
        check("hp_entry2_idx", att_q[ab+2].idx, 2);
        check("hp_next_idx", att_q[ab+3].idx, 0);
        check("hp_next_data", att_q[ab+3].data, 24'h724110);
        check("hp_next_cyc", att_q[ab+3].cyc - att_q[ab+2].cyc, 32 + G + P + 1);
        hotPlug = 1'b0;
        run_to_end("hp");
        check("hp_attempts", att_q.size() - ab, 13);
        check("hp_done", configDone, 1'b1);

        // Hot-plug edge in DONE takes effect on the third edge after the pin rises.
        hotPlug = 1'b1;
        @(negedge refClock);
        check("hp_lat1", configDone, 1'b1);
        @(negedge refClock);
        check("hp_lat2", configDone, 1'b1);
        @(negedge refClock);
        check("hp_lat3", configDone, 1'b0);
        hotPlug = 1'b0;

        // Asynchronous reset while entry 4 waits for acceptance.
        do_reset();
        n = 0;
        while (!(i2cGo && configIndex == 4'd4) && n < 5000) begin
            @(negedge refClock);
            n++;
        end
        check("ar_reached_entry4", 32'(n < 5000), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("ar_go_async", i2cGo, 1'b0);
        check("ar_index", configIndex, 4'd0);
        check("ar_data", i2cData, 24'h724110);
        check("ar_done", configDone, 1'b0);
        check("ar_error", configError, 1'b0);
        @(negedge refClock);
        ab = att_q.size();
        reset_n = 1'b1;
        base = cyc;
        wait_attempts("ar_first", ab + 1);
        check("ar_first_cyc", att_q[ab].cyc - base, P + 1);
        check("ar_first_idx", att_q[ab].idx, 0);
        run_to_end("ar");
        check("ar_attempts", att_q.size() - ab, 10);

        // Randomised stall patterns against the reference timeline.
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 10; i++)
                ign[i] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
            ign_cfg = ign;
            do_reset();
            model(ign);
            run_to_end("rand");
            compare_model("rand_model");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
